// File: rtl/ws2812_frame_sequencer_if.sv
// ws2812_frame_sequencer_if: pixel stream from the source and slot bus to the bit encoder
interface ws2812_frame_sequencer_if;
  logic [23:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        enc_cmd_req;
  logic [1:0]  enc_cmd;
  logic        enc_databit;
  modport master (output pix_data, pix_valid, enc_cmd_req, input pix_ready, enc_cmd, enc_databit);
  modport slave (input pix_data, pix_valid, enc_cmd_req, output pix_ready, enc_cmd, enc_databit);
endinterface

// File: rtl/ws2812_frame_sequencer.sv
// ws2812_frame_sequencer: streams GRB pixels MSB-first into a ws2812 bit encoder, one bit per slot, then latches
module ws2812_frame_sequencer #(
  parameter int LED_COUNT   = 8,
  parameter int RESET_SLOTS = 40
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     frame_start,
  ws2812_frame_sequencer_if.slave  bus,
  output logic                     busy,
  output logic                     done,
  output logic                     underrun
);
  localparam int LW = $clog2(LED_COUNT + 1);
  localparam int RW = $clog2(RESET_SLOTS + 1);
  localparam logic [1:0] S_IDLE = 2'd0, S_LOAD = 2'd1, S_SEND = 2'd2, S_LATCH = 2'd3;
  localparam logic [1:0] CMD_IDLE = 2'b00, CMD_TX = 2'b01, CMD_RESET = 2'b10;
  logic [1:0]    state;
  logic [LW-1:0] led_cnt;
  logic [LW-1:0] acc_cnt;
  logic [RW-1:0] rst_cnt;
  logic [4:0]    bit_cnt;
  logic [23:0]   shift;
  logic [23:0]   pbuf;
  logic          pbuf_full;
  logic          accept;
  logic          last_led;
  logic          slot_end;
  // handshake and end-of-pixel decode; the buffer only asks for pixels the frame still needs
  always_comb begin
    bus.pix_ready = state == S_LOAD || (state == S_SEND && !pbuf_full && acc_cnt < LW'(LED_COUNT));
    accept = bus.pix_valid && bus.pix_ready;
    last_led = led_cnt == LW'(LED_COUNT - 1);
    slot_end = state == S_SEND && bus.enc_cmd_req && bit_cnt == 5'd23;
  end
  assign busy = state != S_IDLE;
  assign bus.enc_databit = shift[23];
  // frame FSM: per-slot command generation, one-entry prefetch buffer, latch countdown
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      bus.enc_cmd <= CMD_IDLE;
      shift <= '0;
      pbuf <= '0;
      pbuf_full <= 1'b0;
      led_cnt <= '0;
      acc_cnt <= '0;
      rst_cnt <= '0;
      bit_cnt <= '0;
      done <= 1'b0;
      underrun <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) acc_cnt <= acc_cnt + LW'(1);
      if (accept && state == S_SEND) pbuf <= bus.pix_data;
      pbuf_full <= (accept && state == S_SEND) || (pbuf_full && !(slot_end && !last_led));
      case (state)
        S_IDLE: if (frame_start && !done) begin
          state <= S_LOAD;
          led_cnt <= '0;
          bit_cnt <= '0;
          acc_cnt <= '0;
          underrun <= 1'b0;
        end
        S_LOAD: if (accept) begin
          state <= S_SEND;
          shift <= bus.pix_data;
          bus.enc_cmd <= CMD_TX;
          bit_cnt <= '0;
        end
        S_SEND: if (bus.enc_cmd_req) begin
          if (bit_cnt != 5'd23) begin
            shift <= shift << 1;
            bit_cnt <= bit_cnt + 5'd1;
          end else if (!last_led && pbuf_full) begin
            shift <= pbuf;
            led_cnt <= led_cnt + LW'(1);
            bit_cnt <= '0;
          end else begin
            state <= S_LATCH;
            bus.enc_cmd <= CMD_RESET;
            shift <= '0;
            rst_cnt <= '0;
            underrun <= !last_led;
          end
        end
        S_LATCH: if (bus.enc_cmd_req) begin
          rst_cnt <= rst_cnt + RW'(1);
          if (rst_cnt == RW'(RESET_SLOTS - 1)) begin
            state <= S_IDLE;
            bus.enc_cmd <= CMD_IDLE;
            done <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
